// File: rtl/divider_pkg.sv
// Shared widths, iteration count and state encoding for the restoring divider.
package divider_pkg;
    localparam int unsigned A_W   = 32;
    localparam int unsigned B_W   = 16;
    localparam int unsigned R_W   = B_W + 1;
    localparam int unsigned ITERS = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module divider_step
    import divider_pkg::*;
(
    input  logic [R_W-1:0] r_in,
    input  logic [A_W-1:0] a_in,
    input  logic [B_W-1:0] b,
    output logic [R_W-1:0] r_out,
    output logic [A_W-1:0] a_out
);
    localparam int unsigned WIDE_W = R_W + 1;

    logic [WIDE_W-1:0] wide;
    logic              fits;

    // Compare one bit wider so no partial-remainder bit is dropped before the trial subtract.
    always_comb begin
        wide  = {r_in, a_in[A_W-1]};
        fits  = (wide >= WIDE_W'(b));
        r_out = fits ? R_W'(wide - WIDE_W'(b)) : R_W'(wide);
        a_out = {a_in[A_W-2:0], fits};
    end
endmodule

// File: rtl/divider.sv
// 32/16 unsigned restoring divider, one quotient bit per cycle, result held on done for HOLD_CYCLES.
// Optional divide-by-zero short cut and div_zero flag: define DIVIDER_DIV_ZERO_DETECT_EN.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 30
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           init,
    output logic           done,
    output logic           busy,
    input  logic [A_W-1:0] op_A,
    input  logic [B_W-1:0] op_B,
    output logic [A_W-1:0] quotient,
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
    output logic           div_zero,
`endif
    output logic [B_W-1:0] remainder
);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t            state;
    logic [A_W-1:0]    a_reg;
    logic [B_W-1:0]    b_reg;
    logic [R_W-1:0]    r_reg;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [A_W-1:0]    a_next;
    logic [R_W-1:0]    r_next;

    divider_step u_step (
        .r_in  (r_reg),
        .a_in  (a_reg),
        .b     (b_reg),
        .r_out (r_next),
        .a_out (a_next)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            busy      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            hold_cnt  <= '0;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
            div_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (init) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    a_reg <= op_A;
                    b_reg <= op_B;
                    r_reg <= '0;
                    cnt   <= '0;
                    state <= S_ITER;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
                    div_zero <= 1'b0;
                    // Zero divisor skips the iterations and reports the saturated result directly.
                    if (op_B == '0) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= '1;
                        remainder <= op_A[B_W-1:0];
                        hold_cnt  <= '0;
                        div_zero  <= 1'b1;
                    end
`endif
                end
                S_ITER: begin
                    a_reg <= a_next;
                    r_reg <= r_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITERS - 1)) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= a_next;
                        remainder <= r_next[B_W-1:0];
                        hold_cnt  <= '0;
                    end
                end
                S_DONE: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BENCH
    string state_name;

    always_comb begin
        case (state)
            S_IDLE:  state_name = "IDLE";
            S_LOAD:  state_name = "LOAD";
            S_ITER:  state_name = "ITER";
            S_DONE:  state_name = "DONE";
            default: state_name = "????";
        endcase
    end
`endif
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 30, number of cycles done stays high before the block returns to idle.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port init  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port done  output  1  result valid, high during DONE.
REQ-006 SHALL have port busy  output  1  high in LOAD and ITER.
REQ-007 SHALL have port op_A  input  32  dividend, unsigned.
REQ-008 SHALL have port op_B  input  16  divisor, unsigned.
REQ-009 SHALL have port quotient  output  32  op_A / op_B.
REQ-010 SHALL have port remainder  output  16  op_A mod op_B.
REQ-011 SHALL have port div_zero  output  1  divide-by-zero flag; exists only per REQ-026.

Function
REQ-012 SHALL implement the FSM IDLE -> LOAD -> ITER -> DONE -> IDLE.
REQ-013 SHALL, in IDLE, move to LOAD when init=1 and stay in IDLE otherwise.
REQ-014 SHALL, in LOAD, capture op_A and op_B, clear the internal 17-bit partial remainder and the 6-bit iteration counter, then go to ITER.
REQ-015 SHALL, in each ITER cycle, do one restoring step: R = {R,A[31]}; A <<= 1; if R >= B then R -= B and A[0] = 1.
REQ-016 SHALL run exactly 32 ITER cycles, then go to DONE.
REQ-017 SHALL, on entry to DONE, load quotient = A and remainder = R[15:0].
REQ-018 SHALL hold quotient and remainder unchanged until the next DONE entry.
REQ-019 SHALL keep done=1 for exactly HOLD_CYCLES cycles, then return to IDLE.
REQ-020 SHALL give this latency: init sampled at cycle 0, done first high at cycle 34.
REQ-021 SHALL ignore init in LOAD, ITER and DONE; op_A and op_B changes after LOAD SHALL NOT affect the result.
REQ-022 SHALL, if init=1 in the IDLE cycle right after DONE, start a new operation with no extra gap.
REQ-023 SHALL, for op_B=0, produce quotient=32'hFFFFFFFF and remainder=op_A[15:0].

Reset
REQ-024 SHALL, when resetn=0 at a clock edge, set state IDLE, done=0, busy=0, quotient=0, remainder=0, div_zero=0.
REQ-025 SHALL let reset mid-operation (LOAD, ITER or DONE) abort the operation with no result update and no done pulse.

Configuration
REQ-026 SHALL gate divide-by-zero handling with the macro DIVIDER_DIV_ZERO_DETECT_EN.
- Defined: LOAD detects op_B=0 and jumps straight to DONE, loading the REQ-023 values and setting div_zero=1; done first high at cycle 2. div_zero clears on the next LOAD.
- Not defined: the div_zero port is absent; op_B=0 runs the full 32 iterations and yields the REQ-023 values at cycle 34.

Structure
REQ-027 SHALL place the state encoding (IDLE, LOAD, ITER, DONE), the dividend/divisor widths and the iteration count constant in shared package divider_pkg.
REQ-028 SHALL place one restoring step (compare/subtract/shift, combinational) in sub-module divider_step, instantiated once.
REQ-029 SHALL, under BENCH, provide a state-name string signal for waveform viewing.

Verification
REQ-030 SHALL cover: op_A=100, op_B=7, init pulse -> quotient=14, remainder=2, done high cycles 34..63, busy high cycles 1..33.
REQ-031 SHALL cover: op_A=32'hFFFFFFFF, op_B=1 -> quotient=32'hFFFFFFFF, remainder=0; op_A=32'hFFFFFFFF, op_B=16'hFFFF -> quotient=32'h00010001, remainder=0.
REQ-032 SHALL cover: op_A=5, op_B=0 -> quotient=32'hFFFFFFFF, remainder=5; div_zero=1 with done at cycle 2 if the macro is defined, done at cycle 34 if not.
REQ-033 SHALL cover: resetn=0 at cycle 15 of an operation -> IDLE next cycle, all outputs 0, no done pulse.
REQ-034 SHALL cover: init held high throughout and operands changed at cycle 5 -> result uses the LOAD-cycle operands; second operation starts in the IDLE cycle after DONE.
REQ-035 SHALL cover: random 200-operation sweep checked against a reference model.
